iob_pcie_rx_chnl: RTL and testbench
===================================

# iob_pcie_rx_chnl

Receive-channel engine between the RIFFA-style PCIe RX channel and the CPU-side RX buffer of the iob_pcie peripheral. It detects a new inbound transaction, pulses the channel acknowledge and latches the transfer length. It then pulls 64-bit words with PCIE_CHNL_RX_DATA_REN_o under downstream back-pressure and presents them as a valid/ready stream with per-beat 32-bit keep and a last flag. It also reports done and error status to the software register bank.

## Interface
- DATA_W, 32: length/status word width.
- C_PCI_DATA_WIDTH, 64: channel data width; only 64 supported; KEEP_W = C_PCI_DATA_WIDTH/32 = 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- PCIE_CHNL_RX_i  in  1  transaction active.
- PCIE_CHNL_RX_LAST_i  in  1  last transaction of sequence.
- PCIE_CHNL_RX_LEN_i  in  DATA_W  length in 32-bit words.
- PCIE_CHNL_RX_OFF_i  in  DATA_W-1  offset; latched and reported only.
- PCIE_CHNL_RX_DATA_i  in  C_PCI_DATA_WIDTH  receive data.
- PCIE_CHNL_RX_DATA_VALID_i  in  1  data valid.
- PCIE_CHNL_RX_ACK_o  out  1  one-cycle acknowledge.
- PCIE_CHNL_RX_DATA_REN_o  out  1  data read enable.
- m_data_o  out  C_PCI_DATA_WIDTH  stream data.
- m_keep_o  out  KEEP_W  bit0 = low word valid, bit1 = high word valid.
- m_last_o  out  1  final beat of transfer.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- len_o  out  DATA_W  latched length.
- off_o  out  DATA_W-1  latched offset.
- seq_last_o  out  1  latched RX_LAST.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at transfer completion.
- err_o  out  1  sticky truncation flag; cleared at the next transaction start.

## Operation
- **States:** IDLE, ACK, DATA, DRAIN.
- **IDLE:**
  - PCIE_CHNL_RX_i=1: latch LEN, OFF and LAST; set rem=LEN; clear err_o; go to ACK.
- **ACK:**
  - PCIE_CHNL_RX_ACK_o=1 for exactly this cycle.
  - Go to DRAIN if rem==0, else to DATA.
- **DATA:**
  - REN = (!m_valid_o | m_ready_i).
  - A beat is accepted when REN & DATA_VALID. On acceptance:
    - load the output register;
    - m_keep_o = (rem>=2) ? 2'b11 : 2'b01;
    - m_last_o = (rem<=2);
    - rem -= min(rem,2).
  - Go to DRAIN on the last beat.
  - If PCIE_CHNL_RX_i falls while rem>0 and no beat is accepted that cycle: set err_o=1 and go to DRAIN. No last beat is produced.
- **DRAIN:**
  - REN=0.
  - Wait until the output register is empty (or emptying this cycle) and PCIE_CHNL_RX_i==0.
  - Then pulse done_o and go to IDLE.
- **Width rules:**
  - rem is DATA_W bits and never underflows.
  - Odd LEN gives a final keep of 2'b01. The high word of that beat is passed through unmodified.
- Data beats arriving while REN=0 are not consumed; that is the RIFFA contract.

## Timing
- **Reset values:** state=IDLE; all outputs 0, including m_data_o, len_o, off_o and err_o.
- **Start latency:**
  - PCIE_CHNL_RX_i seen high in cycle t → ACK high in t+1.
  - REN is high from t+2 at the earliest.
- **Data path:**
  - Beat accepted in cycle k → m_valid_o high in k+1.
  - Sustained throughput is 1 beat/cycle with m_ready_i=1.
- **Back-pressure:**
  - m_valid_o & !m_ready_i deasserts REN combinationally in the same cycle.
  - Data and keep are held stable until the handshake.
- **Completion:** done_o pulses in the cycle the last beat handshakes, if PCIE_CHNL_RX_i is already low; otherwise at the first cycle it is low.
- **Simultaneous events:**
  - A new PCIE_CHNL_RX_i in the done cycle is sampled in IDLE on the next cycle.
  - A beat accepted in the same cycle PCIE_CHNL_RX_i falls counts as valid.
- **Reset mid-transfer:**
  - Returns to IDLE next cycle and drops m_valid_o; no done_o pulse.
  - A still-high PCIE_CHNL_RX_i then starts a new ACK.

## Structure
- **Shared package iob_pcie_pkg:**
  - state encoding (2-bit);
  - C_PCI_DATA_WIDTH;
  - KEEP_W;
  - WORDS_PER_BEAT=2.
- **Sub-module iob_pcie_rx_obuf:** single-entry output register holding data, keep and last with valid/ready. The FSM, rem counter and status registers live in the top.

## Test plan
- **Even length:** LEN=8, VALID always 1, m_ready=1 → ACK one cycle at t+1; 4 beats with keep=11; last on beat 4; done_o one cycle; len_o=8.
- **Odd length:** LEN=5 → 3 beats; keep 11, 11, 01; last only on beat 3; rem ends at 0.
- **Zero length:** LEN=0 → ACK pulse; no m_valid_o; done_o once PCIE_CHNL_RX_i falls; err_o=0.
- **Back-pressure:** LEN=6, m_ready toggles 1,0,0,1 repeatedly → REN low while stalled; no beat lost or duplicated; output data equals the input sequence.
- **Truncation:** LEN=10, PCIE_CHNL_RX_i drops after 2 beats → err_o=1; no m_last_o; done_o pulses; err_o clears at the next start.
- **Reset mid-DATA:** rst after beat 1 of LEN=8 → all outputs 0 next cycle; a fresh transaction then completes normally.

Source files
------------

// File: rtl/iob_pcie_pkg.sv
// Shared types and widths for the iob_pcie RIFFA channel engines.
// State encoding and beat geometry used by the RX path.
package iob_pcie_pkg;

  localparam int C_PCI_DATA_WIDTH = 64;
  localparam int KEEP_W = C_PCI_DATA_WIDTH / 32;
  localparam int WORDS_PER_BEAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_DATA,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/iob_pcie_rx_obuf.sv
// Single-entry output register for the RX stream.
// Holds data, keep and last stable until the consumer takes them.
module iob_pcie_rx_obuf
  import iob_pcie_pkg::*;
#(
  parameter int W  = C_PCI_DATA_WIDTH,
  parameter int KW = KEEP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic [KW-1:0] kin,
  input  logic          lin,
  output logic [W-1:0]  data,
  output logic [KW-1:0] keep,
  output logic          last,
  output logic          valid,
  input  logic          ready,
  output logic          free
);

  // Free when empty or when the held beat leaves this cycle.
  assign free = !valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      keep  <= kin;
      last  <= lin;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/iob_pcie_rx_chnl.sv
// RIFFA RX channel engine: ack, length latch, beat pull under
// back-pressure, keep/last generation and done/error status.
module iob_pcie_rx_chnl
  import iob_pcie_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int C_PCI_DATA_WIDTH = iob_pcie_pkg::C_PCI_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PCIE_CHNL_RX_i,
  input  logic                        PCIE_CHNL_RX_LAST_i,
  input  logic [DATA_W-1:0]           PCIE_CHNL_RX_LEN_i,
  input  logic [DATA_W-2:0]           PCIE_CHNL_RX_OFF_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA_i,
  input  logic                        PCIE_CHNL_RX_DATA_VALID_i,
  output logic                        PCIE_CHNL_RX_ACK_o,
  output logic                        PCIE_CHNL_RX_DATA_REN_o,
  output logic [C_PCI_DATA_WIDTH-1:0] m_data_o,
  output logic [KEEP_W-1:0]           m_keep_o,
  output logic                        m_last_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_W-1:0]           len_o,
  output logic [DATA_W-2:0]           off_o,
  output logic                        seq_last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  state_t              state;
  logic [DATA_W-1:0]   rem;
  logic                free;
  logic                accept;
  logic                rem_ge2;
  logic                beat_last;
  logic [DATA_W-1:0]   step;
  logic [KEEP_W-1:0]   beat_keep;

  assign rem_ge2   = rem >= DATA_W'(WORDS_PER_BEAT);
  assign beat_last = rem <= DATA_W'(WORDS_PER_BEAT);
  assign step      = rem_ge2 ? DATA_W'(WORDS_PER_BEAT) : DATA_W'(1);
  assign beat_keep = rem_ge2 ? {KEEP_W{1'b1}} : KEEP_W'(1);

  assign PCIE_CHNL_RX_DATA_REN_o = (state == ST_DATA) & free;
  assign accept = PCIE_CHNL_RX_DATA_REN_o & PCIE_CHNL_RX_DATA_VALID_i;

  assign busy_o = state != ST_IDLE;
  // Completion waits for the last beat to leave and the channel to close.
  assign done_o = (state == ST_DRAIN) & free & !PCIE_CHNL_RX_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      rem                <= '0;
      len_o              <= '0;
      off_o              <= '0;
      seq_last_o         <= 1'b0;
      err_o              <= 1'b0;
      PCIE_CHNL_RX_ACK_o <= 1'b0;
    end else begin
      PCIE_CHNL_RX_ACK_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (PCIE_CHNL_RX_i) begin
            len_o              <= PCIE_CHNL_RX_LEN_i;
            off_o              <= PCIE_CHNL_RX_OFF_i;
            seq_last_o         <= PCIE_CHNL_RX_LAST_i;
            rem                <= PCIE_CHNL_RX_LEN_i;
            err_o              <= 1'b0;
            PCIE_CHNL_RX_ACK_o <= 1'b1;
            state              <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= (rem == '0) ? ST_DRAIN : ST_DATA;
        end
        ST_DATA: begin
          if (accept) begin
            rem <= rem - step;
            if (beat_last) state <= ST_DRAIN;
          end else if (!PCIE_CHNL_RX_i) begin
            err_o <= 1'b1;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (done_o) state <= ST_IDLE;
        end
      endcase
    end
  end

  iob_pcie_rx_obuf #(
    .W  (C_PCI_DATA_WIDTH),
    .KW (KEEP_W)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .din   (PCIE_CHNL_RX_DATA_i),
    .kin   (beat_keep),
    .lin   (beat_last),
    .data  (m_data_o),
    .keep  (m_keep_o),
    .last  (m_last_o),
    .valid (m_valid_o),
    .ready (m_ready_i),
    .free  (free)
  );

endmodule

// File: tb/tb_iob_pcie_rx_chnl.sv
// Directed bench for iob_pcie_rx_chnl: transaction table plus
// hand-written reset-in-flight sequence.
module tb_iob_pcie_rx_chnl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rx_last_in;
  logic [31:0] rx_len;
  logic [30:0] rx_off;
  logic [63:0] rx_data;
  logic        data_valid;
  logic        ack;
  logic        ren;
  logic [63:0] m_data;
  logic [1:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] len;
  logic [30:0] off;
  logic        seq_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_pcie_rx_chnl dut (
    .clk                       (clk),
    .rst                       (rst),
    .PCIE_CHNL_RX_i            (rx),
    .PCIE_CHNL_RX_LAST_i       (rx_last_in),
    .PCIE_CHNL_RX_LEN_i        (rx_len),
    .PCIE_CHNL_RX_OFF_i        (rx_off),
    .PCIE_CHNL_RX_DATA_i       (rx_data),
    .PCIE_CHNL_RX_DATA_VALID_i (data_valid),
    .PCIE_CHNL_RX_ACK_o        (ack),
    .PCIE_CHNL_RX_DATA_REN_o   (ren),
    .m_data_o                  (m_data),
    .m_keep_o                  (m_keep),
    .m_last_o                  (m_last),
    .m_valid_o                 (m_valid),
    .m_ready_i                 (m_ready),
    .len_o                     (len),
    .off_o                     (off),
    .seq_last_o                (seq_last),
    .busy_o                    (busy),
    .done_o                    (done),
    .err_o                     (err)
  );

  typedef struct {
    int       len;
    int       trunc;
    int       hold;
    bit       bp;
    int       exp_beats;
    bit [1:0] exp_klast;
    bit       exp_err;
    int       exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int id, input int i);
    return {8'(id), 24'(2 * i + 1), 8'(id), 24'(2 * i)};
  endfunction

  task automatic run_txn(input vec_t v, input int id);
    int n_src, src, beats, dones, acks, ack_c, done_c, remw;
    logic [1:0] klast;
    logic       err_done;
    bit [3:0]   pat;
    pat = 4'b1001;
    n_src = (v.trunc != 0) ? v.trunc : (v.len + 1) / 2;
    src = 0; beats = 0; dones = 0; acks = 0;
    ack_c = -1; done_c = -1; klast = 2'b00; err_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rx = (c == 0) || (c < v.hold) || (src < n_src);
      rx_len = v.len;
      rx_off = 31'(id * 16 + 3);
      rx_last_in = id[0];
      data_valid = (src < n_src);
      rx_data = word(id, src);
      m_ready = v.bp ? pat[c % 4] : 1'b1;
      #1;
      if (ack) begin
        acks++;
        if (ack_c < 0) ack_c = c;
      end
      if (c == 1) begin
        chk("err_clear_at_start", err, 1'b0);
        chk("busy_in_ack", busy, 1'b1);
      end
      if (m_valid && !m_ready) chk("ren_low_stalled", ren, 1'b0);
      if (m_valid && m_ready) begin
        remw = v.len - 2 * beats;
        chk("beat_data", m_data, word(id, beats));
        chk("beat_keep", m_keep, (remw >= 2) ? 2'b11 : 2'b01);
        chk("beat_last", m_last, (remw <= 2) ? 1'b1 : 1'b0);
        klast = m_keep;
        beats++;
      end
      if (ren && data_valid) src++;
      if (done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          err_done = err;
          chk("rx_low_at_done", rx, 1'b0);
          chk("len_latched", len, 64'(v.len));
          chk("off_latched", off, 64'(id * 16 + 3));
          chk("seq_last_latched", seq_last, id[0]);
        end
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("idle_after_done", busy, 1'b0);
        break;
      end
    end
    if (done_c < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL txn%0d_timeout: no done within 300 cycles", id);
    end
    chk("ack_count", acks, 1);
    chk("ack_cycle", ack_c, 1);
    chk("beat_count", beats, v.exp_beats);
    chk("done_count", dones, 1);
    chk("err_at_done", err_done, v.exp_err);
    if (v.exp_beats > 0) chk("final_keep", klast, v.exp_klast);
    if (v.exp_done >= 0) chk("done_cycle", done_c, v.exp_done);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8,  0, 0, 1'b0, 4, 2'b11, 1'b0, 6};
    vecs[1] = '{5,  0, 0, 1'b0, 3, 2'b01, 1'b0, 5};
    vecs[2] = '{0,  0, 4, 1'b0, 0, 2'b00, 1'b0, 4};
    vecs[3] = '{6,  0, 0, 1'b1, 3, 2'b11, 1'b0, -1};
    vecs[4] = '{10, 2, 0, 1'b0, 2, 2'b11, 1'b1, 5};
    vecs[5] = '{7,  0, 0, 1'b0, 4, 2'b01, 1'b0, 6};
    vecs[6] = '{3,  0, 0, 1'b1, 2, 2'b01, 1'b0, -1};

    rst = 1'b1; rx = 1'b0; rx_last_in = 1'b0;
    rx_len = '0; rx_off = '0; rx_data = '0;
    data_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 64'h0);
    chk("rst_len", len, 64'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i + 1);

    // Reset in the middle of a LEN=8 transfer.
    @(negedge clk);
    rx = 1'b1; rx_len = 8; rx_off = 31'h5;
    data_valid = 1'b1; rx_data = word(9, 0); m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_data = word(9, 1);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", m_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_data", m_data, 64'h0);
    chk("mid_rst_keep", m_keep, 2'b00);
    chk("mid_rst_len", len, 64'h0);
    chk("mid_rst_ren", ren, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_restart_ack", ack, 1'b1);
    chk("rst_restart_len", len, 64'd8);
    rst = 1'b1; rx = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(vecs[0], 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
